// File: rtl/seq_rca.sv
// rtl/seq_rca.sv - sequential ripple-carry adder/subtractor, CHUNK bits per clock
module seq_rca #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    K_LAST = KW'(N - 1);
    localparam logic [WIDTH-1:0] MASK   = ~({WIDTH{1'b1}} << CHUNK);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  part_q, part_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;

    logic [31:0]       sh;
    logic [CHUNK-1:0]  a_chk, b_chk;
    logic [CHUNK:0]    sum_chk;
    logic              c_msb;
    logic [WIDTH-1:0]  part_ins;

    // Slice out chunk k, add it, and splice the result bits into the partial word.
    assign sh       = 32'(k_q) * CHUNK;
    assign a_chk    = CHUNK'(a_q >> sh);
    assign b_chk    = CHUNK'(b_q >> sh);
    assign sum_chk  = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry_q};
    assign c_msb    = sum_chk[CHUNK-1] ^ a_chk[CHUNK-1] ^ b_chk[CHUNK-1];
    assign part_ins = (part_q & ~(MASK << sh)) | (WIDTH'(sum_chk[CHUNK-1:0]) << sh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        part_d  = part_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + ~c_in, so c_out reads as not-borrow.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = c_in ^ sub;
                    k_d     = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                part_d  = part_ins;
                carry_d = sum_chk[CHUNK];
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    sum_d   = part_ins;
                    c_out_d = sum_chk[CHUNK];
                    ovf_d   = c_msb ^ sum_chk[CHUNK];
                    k_d     = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_rca.sv
// tb/tb_seq_rca.sv - self-checking bench for seq_rca (CHUNK=2, 8 and 1 builds)
module tb_seq_rca;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, c_in, sub;
    logic [7:0] a, b;

    logic       busy, done, c_out, overflow;
    logic [7:0] sum;
    logic       busy_c8, done_c8, c_out_c8, overflow_c8;
    logic [7:0] sum_c8;
    logic       busy_c1, done_c1, c_out_c1, overflow_c1;
    logic [7:0] sum_c1;

    seq_rca #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    seq_rca #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .busy(busy_c8), .done(done_c8), .sum(sum_c8), .c_out(c_out_c8), .overflow(overflow_c8)
    );

    seq_rca #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .busy(busy_c1), .done(done_c1), .sum(sum_c1), .c_out(c_out_c1), .overflow(overflow_c1)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] prev_sum = 8'h00;
    logic       prev_co  = 1'b0;
    logic       prev_ov  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: plain integer arithmetic on the operands as written.
    task automatic model(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                         input logic ss, output logic [7:0] es, output logic ec,
                         output logic eo);
        int u, r;
        if (ss) begin
            u  = int'(aa) - int'(bb) - int'(cc);
            r  = int'($signed(aa)) - int'($signed(bb)) - int'(cc);
            ec = (u >= 0);
        end else begin
            u  = int'(aa) + int'(bb) + int'(cc);
            r  = int'($signed(aa)) + int'($signed(bb)) + int'(cc);
            ec = (u > 255);
        end
        es = u[7:0];
        eo = (r > 127) || (r < -128);
    endtask

    task automatic launch(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                          input logic ss);
        a     = aa;
        b     = bb;
        c_in  = cc;
        sub   = ss;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
    endtask

    task automatic finish_op(input string tag, input int n, input logic [7:0] es,
                             input logic ec, input logic eo);
        while (done !== 1'b1 && cyc < 20) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".hold"}, 32'({overflow, c_out, sum}), 32'({prev_ov, prev_co, prev_sum}));
            step();
        end
        check({tag, ".done"},  32'(done), 32'd1);
        check({tag, ".lat"},   32'(cyc), 32'(n));
        check({tag, ".sum"},   32'(sum), 32'(es));
        check({tag, ".c_out"}, 32'(c_out), 32'(ec));
        check({tag, ".ovf"},   32'(overflow), 32'(eo));
        check({tag, ".idle"},  32'(busy), 32'd0);
        prev_sum = es;
        prev_co  = ec;
        prev_ov  = eo;
    endtask

    initial begin
        logic [7:0] ra, rb, es;
        logic       rc, rs, ec, eo;
        int         lat8, lat1;

        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0; sub = 1'b0;
        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.out",  32'({overflow, c_out, sum}), 32'd0);
        step();
        rst = 1'b0;
        step();

        launch(8'h3C, 8'h5A, 1'b0, 1'b0);
        finish_op("add_3c_5a", 4, 8'h96, 1'b0, 1'b1);
        step();
        check("after_done.done", 32'(done), 32'd0);
        check("after_done.busy", 32'(busy), 32'd0);

        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        finish_op("add_ff_01", 4, 8'h00, 1'b1, 1'b0);
        launch(8'hFF, 8'h01, 1'b1, 1'b0);
        finish_op("add_ff_01_c", 4, 8'h01, 1'b1, 1'b0);
        launch(8'h10, 8'h20, 1'b0, 1'b1);
        finish_op("sub_10_20", 4, 8'hF0, 1'b0, 1'b0);
        launch(8'h80, 8'h01, 1'b0, 1'b1);
        finish_op("sub_80_01", 4, 8'h7F, 1'b1, 1'b1);
        step();

        launch(8'h3C, 8'h5A, 1'b0, 1'b0);
        a = 8'hFF; b = 8'hFF; c_in = 1'b1; sub = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        finish_op("ignore_start", 4, 8'h96, 1'b0, 1'b1);
        launch(8'h01, 8'h02, 1'b0, 1'b0);
        finish_op("back_to_back", 4, 8'h03, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rc, rs, es, ec, eo);
            if ($urandom_range(0, 1) == 1) begin
                step();
                check("rand.gap_done", 32'(done), 32'd0);
            end
            launch(ra, rb, rc, rs);
            finish_op("rand", 4, es, ec, eo);
        end

        launch(8'h3C, 8'h5A, 1'b0, 1'b0);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.out",  32'({overflow, c_out, sum}), 32'd0);
        step();
        step();
        check("abort.held_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();
        check("abort.post_done", 32'(done), 32'd0);
        check("abort.post_busy", 32'(busy), 32'd0);
        prev_sum = 8'h00; prev_co = 1'b0; prev_ov = 1'b0;
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        finish_op("post_rst", 4, 8'h02, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) step();
        launch(8'h3C, 8'h5A, 1'b0, 1'b0);
        lat8 = -1;
        lat1 = -1;
        for (int i = 0; i < 20; i++) begin
            if (lat8 < 0 && lat1 < 0 && i > 0) break;
            step();
            if (done_c8 === 1'b1 && lat8 < 0) begin
                lat8 = cyc;
                check("c8.sum", 32'(sum_c8), 32'h96);
            end
            if (done_c1 === 1'b1 && lat1 < 0) begin
                lat1 = cyc;
                check("c1.sum", 32'(sum_c1), 32'h96);
            end
        end
        for (int i = 0; i < 20 && (lat8 < 0 || lat1 < 0); i++) begin
            step();
            if (done_c8 === 1'b1 && lat8 < 0) begin
                lat8 = cyc;
                check("c8.sum", 32'(sum_c8), 32'h96);
            end
            if (done_c1 === 1'b1 && lat1 < 0) begin
                lat1 = cyc;
                check("c1.sum", 32'(sum_c1), 32'h96);
            end
        end
        check("c8.lat", 32'(lat8), 32'd1);
        check("c1.lat", 32'(lat1), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
